// File: rtl/kgp_ctrl_pkg.sv
// rtl/kgp_ctrl_pkg.sv - shared opcodes, ALU codes, state and class enums for the KGP control unit
package kgp_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd1;
   localparam logic [5:0] OP_COMPI = 6'd2;
   localparam logic [5:0] OP_LW    = 6'd3;
   localparam logic [5:0] OP_SW    = 6'd4;
   localparam logic [5:0] OP_B     = 6'd5;
   localparam logic [5:0] OP_BLTZ  = 6'd6;
   localparam logic [5:0] OP_BZ    = 6'd7;
   localparam logic [5:0] OP_BNZ   = 6'd8;
   localparam logic [5:0] OP_BCY   = 6'd9;
   localparam logic [5:0] OP_BNCY  = 6'd10;
   localparam logic [5:0] OP_HALT  = 6'd11;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_COMP = 3'd1;
   localparam logic [2:0] ALU_SL   = 3'd2;
   localparam logic [2:0] ALU_SRL  = 3'd3;
   localparam logic [2:0] ALU_SRA  = 3'd4;
   localparam logic [2:0] ALU_DIFF = 3'd5;
   localparam logic [2:0] ALU_AND  = 3'd6;
   localparam logic [2:0] ALU_XOR  = 3'd7;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_R    = 3'd0,
      CLS_I    = 3'd1,
      CLS_LW   = 3'd2,
      CLS_SW   = 3'd3,
      CLS_BR   = 3'd4,
      CLS_HALT = 3'd5,
      CLS_ILL  = 3'd6
   } class_t;

endpackage

// File: rtl/kgp_instr_decode.sv
// rtl/kgp_instr_decode.sv - combinational opcode/funct decode into class, ALU control and operand select
module kgp_instr_decode
   import kgp_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 5
)
(
   input  logic [OPW-1:0] i_op,
   input  logic [FNW-1:0] i_fn,
   output logic [2:0]     o_class,
   output logic [2:0]     o_alu_control,
   output logic           o_alu_src,
   output logic           o_illegal
);

   always_comb begin
      o_class       = CLS_ILL;
      o_alu_control = ALU_ADD;
      o_alu_src     = 1'b0;
      o_illegal     = 1'b0;
      case (i_op)
         OP_RTYPE: begin
            // funct[4:3] are reserved; any set bit makes the R-type word illegal
            o_alu_control = i_fn[2:0];
            o_illegal     = |i_fn[4:3];
            o_class       = o_illegal ? CLS_ILL : CLS_R;
         end
         OP_ADDI: begin
            o_class   = CLS_I;
            o_alu_src = 1'b1;
         end
         OP_COMPI: begin
            o_class       = CLS_I;
            o_alu_control = ALU_COMP;
            o_alu_src     = 1'b1;
         end
         OP_LW: begin
            o_class   = CLS_LW;
            o_alu_src = 1'b1;
         end
         OP_SW: begin
            o_class   = CLS_SW;
            o_alu_src = 1'b1;
         end
         OP_B, OP_BLTZ, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY: o_class = CLS_BR;
         OP_HALT: o_class = CLS_HALT;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/kgp_control_fsm.sv
// rtl/kgp_control_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control unit for the KGP miniRISC datapath
module kgp_control_fsm
   import kgp_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 5
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_instr,
   input  logic        i_instr_valid,
   input  logic        i_mem_ready,
   input  logic        i_zero_flag,
   input  logic        i_msb_flag,
   input  logic        i_carry_flag,
   output logic        o_imem_req,
   output logic        o_ir_write,
   output logic [2:0]  o_alu_control,
   output logic        o_alu_src,
   output logic        o_reg_write,
   output logic        o_mem_read,
   output logic        o_mem_write,
   output logic        o_mem_to_reg,
   output logic        o_pc_write,
   output logic        o_pc_src,
   output logic        o_halted,
   output logic        o_illegal_instr,
   output logic [2:0]  o_state_dbg
);

   state_t         r_state;
   logic [OPW-1:0] r_ir_op;
   logic [FNW-1:0] r_ir_fn;
   logic           r_carry_reg;
   logic           r_halted;
   logic           r_illegal;

   logic [2:0]     w_class;
   logic [2:0]     w_alu_control;
   logic           w_alu_src;
   logic           w_illegal;
   logic           w_taken;
   logic           w_carry_upd;
   logic           w_unused;

   assign w_unused = ^i_instr[31-OPW:FNW];

   kgp_instr_decode #(.OPW(OPW), .FNW(FNW)) u_decode (
      .i_op          (r_ir_op),
      .i_fn          (r_ir_fn),
      .o_class       (w_class),
      .o_alu_control (w_alu_control),
      .o_alu_src     (w_alu_src),
      .o_illegal     (w_illegal)
   );

   always_comb begin
      w_taken = 1'b0;
      case (r_ir_op)
         OP_B:    w_taken = 1'b1;
         OP_BLTZ: w_taken = i_msb_flag;
         OP_BZ:   w_taken = i_zero_flag;
         OP_BNZ:  w_taken = !i_zero_flag;
         OP_BCY:  w_taken = r_carry_reg;
         OP_BNCY: w_taken = !r_carry_reg;
         default: w_taken = 1'b0;
      endcase
   end

   // Only the adding instructions (R-type add, addi) define a carry for bcy/bncy
   assign w_carry_upd = ((w_class == CLS_R) && (r_ir_fn == '0)) || (r_ir_op == OP_ADDI);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_FETCH;
         r_ir_op     <= '0;
         r_ir_fn     <= '0;
         r_carry_reg <= 1'b0;
         r_halted    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: if (i_instr_valid) begin
               r_ir_op <= i_instr[31 -: OPW];
               r_ir_fn <= i_instr[FNW-1:0];
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               if (w_class == CLS_HALT) begin
                  r_halted <= 1'b1;
                  r_state  <= ST_HALT;
               end else if (w_illegal) begin
                  r_illegal <= 1'b1;
                  r_halted  <= 1'b1;
                  r_state   <= ST_HALT;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_carry_upd) r_carry_reg <= i_carry_flag;
               case (w_class)
                  CLS_LW, CLS_SW: r_state <= ST_MEM;
                  CLS_BR:         r_state <= ST_FETCH;
                  default:        r_state <= ST_WB;
               endcase
            end
            ST_MEM: if (i_mem_ready) r_state <= (r_ir_op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:   r_state <= ST_FETCH;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      o_imem_req    = 1'b0;
      o_ir_write    = 1'b0;
      o_alu_control = ALU_ADD;
      o_alu_src     = 1'b0;
      o_reg_write   = 1'b0;
      o_mem_read    = 1'b0;
      o_mem_write   = 1'b0;
      o_mem_to_reg  = 1'b0;
      o_pc_write    = 1'b0;
      o_pc_src      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            o_imem_req = 1'b1;
            o_ir_write = i_instr_valid;
            o_pc_write = i_instr_valid;
         end
         ST_EXEC: begin
            o_alu_control = w_alu_control;
            o_alu_src     = w_alu_src;
            o_pc_write    = (w_class == CLS_BR) && w_taken;
            o_pc_src      = (w_class == CLS_BR) && w_taken;
         end
         ST_MEM: begin
            o_mem_read  = (r_ir_op == OP_LW);
            o_mem_write = (r_ir_op == OP_SW);
         end
         ST_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = (r_ir_op == OP_LW);
         end
         default: ;
      endcase
      // Reset abandons any in-flight handshake immediately, not at the next edge
      if (i_rst) begin
         o_imem_req   = 1'b0;
         o_ir_write   = 1'b0;
         o_reg_write  = 1'b0;
         o_mem_read   = 1'b0;
         o_mem_write  = 1'b0;
         o_mem_to_reg = 1'b0;
         o_pc_write   = 1'b0;
         o_pc_src     = 1'b0;
      end
   end

   assign o_halted        = r_halted;
   assign o_illegal_instr = r_illegal;
   assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_kgp_control_fsm.sv
// tb/tb_kgp_control_fsm.sv - directed self-checking bench for kgp_control_fsm
module tb_kgp_control_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        mem_ready = 1'b0;
   logic        zero_flag = 1'b0;
   logic        msb_flag = 1'b0;
   logic        carry_flag = 1'b0;
   logic        imem_req, ir_write, alu_src, reg_write, mem_read, mem_write;
   logic        mem_to_reg, pc_write, pc_src, halted, illegal_instr;
   logic [2:0]  alu_control, state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kgp_control_fsm dut (
      .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(instr_valid),
      .i_mem_ready(mem_ready), .i_zero_flag(zero_flag), .i_msb_flag(msb_flag),
      .i_carry_flag(carry_flag), .o_imem_req(imem_req), .o_ir_write(ir_write),
      .o_alu_control(alu_control), .o_alu_src(alu_src), .o_reg_write(reg_write),
      .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg),
      .o_pc_write(pc_write), .o_pc_src(pc_src), .o_halted(halted),
      .o_illegal_instr(illegal_instr), .o_state_dbg(state_dbg)
   );

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] fn);
      return {op, 21'd0, fn};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in FETCH and advance to the start of EXEC
   task automatic to_exec(input logic [5:0] op, input logic [4:0] fn);
      instr = mk(op, fn);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      instr = mk(6'd0, 5'd0);
      instr_valid = 1'b1;
      step();
      step();
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
      checks++; if ({imem_req, ir_write, pc_write} !== 3'b000) begin errors++; $display("FAIL rst_forced_en got %b exp 000", {imem_req, ir_write, pc_write}); end
      checks++; if ({halted, illegal_instr} !== 2'b00) begin errors++; $display("FAIL rst_sticky got %b exp 00", {halted, illegal_instr}); end
      checks++; if (dut.r_carry_reg !== 1'b0) begin errors++; $display("FAIL rst_carry got %b exp 0", dut.r_carry_reg); end
      instr_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_imem got %b exp 1", imem_req); end
   endtask

   task automatic test_rtype_add();
      instr = mk(6'd0, 5'd0);
      instr_valid = 1'b1;
      #1;
      checks++; if ({state_dbg, ir_write, pc_write, pc_src, reg_write} !== {3'd0, 4'b1100}) begin errors++; $display("FAIL radd_c1 got %b exp 0001100", {state_dbg, ir_write, pc_write, pc_src, reg_write}); end
      step();
      instr_valid = 1'b0;
      checks++; if ({state_dbg, imem_req, ir_write, pc_write, reg_write} !== {3'd1, 4'b0000}) begin errors++; $display("FAIL radd_c2 got %b exp 0010000", {state_dbg, imem_req, ir_write, pc_write, reg_write}); end
      step();
      carry_flag = 1'b1;
      #1;
      checks++; if ({state_dbg, alu_control, alu_src, reg_write, pc_write} !== {3'd2, 3'd0, 3'b000}) begin errors++; $display("FAIL radd_c3 got %b exp 010000000", {state_dbg, alu_control, alu_src, reg_write, pc_write}); end
      step();
      carry_flag = 1'b0;
      checks++; if ({state_dbg, reg_write, mem_to_reg} !== {3'd4, 2'b10}) begin errors++; $display("FAIL radd_c4 got %b exp 10010", {state_dbg, reg_write, mem_to_reg}); end
      step();
      checks++; if ({state_dbg, reg_write} !== {3'd0, 1'b0}) begin errors++; $display("FAIL radd_back got %b exp 0000", {state_dbg, reg_write}); end
      checks++; if (dut.r_carry_reg !== 1'b1) begin errors++; $display("FAIL radd_carry got %b exp 1", dut.r_carry_reg); end
   endtask

   task automatic test_rtype_xor();
      to_exec(6'd0, 5'd7);
      carry_flag = 1'b0;
      #1;
      checks++; if ({alu_control, alu_src} !== {3'd7, 1'b0}) begin errors++; $display("FAIL rxor_alu got %b exp 1110", {alu_control, alu_src}); end
      step();
      step();
      checks++; if (dut.r_carry_reg !== 1'b1) begin errors++; $display("FAIL rxor_carry_kept got %b exp 1", dut.r_carry_reg); end
   endtask

   task automatic test_lw_wait();
      int cyc;
      cyc = 0;
      instr = mk(6'd3, 5'd0);
      instr_valid = 1'b1;
      step(); cyc++;
      instr_valid = 1'b0;
      step(); cyc++;
      checks++; if ({state_dbg, alu_control, alu_src} !== {3'd2, 3'd0, 1'b1}) begin errors++; $display("FAIL lw_exec got %b exp 0100001", {state_dbg, alu_control, alu_src}); end
      step(); cyc++;
      for (int i = 0; i < 3; i++) begin
         mem_ready = (i == 2);
         #1;
         checks++; if ({state_dbg, mem_read, mem_write} !== {3'd3, 2'b10}) begin errors++; $display("FAIL lw_mem%0d got %b exp 01110", i, {state_dbg, mem_read, mem_write}); end
         step(); cyc++;
      end
      mem_ready = 1'b0;
      checks++; if ({state_dbg, reg_write, mem_to_reg, mem_read} !== {3'd4, 3'b110}) begin errors++; $display("FAIL lw_wb got %b exp 100110", {state_dbg, reg_write, mem_to_reg, mem_read}); end
      step(); cyc++;
      checks++; if (state_dbg !== 3'd0 || cyc !== 7) begin errors++; $display("FAIL lw_total got state %0d cycles %0d exp state 0 cycles 7", state_dbg, cyc); end
   endtask

   task automatic test_sw_nowait();
      to_exec(6'd4, 5'd0);
      step();
      mem_ready = 1'b1;
      #1;
      checks++; if ({state_dbg, mem_write, mem_read, reg_write} !== {3'd3, 3'b100}) begin errors++; $display("FAIL sw_mem got %b exp 011100", {state_dbg, mem_write, mem_read, reg_write}); end
      step();
      mem_ready = 1'b0;
      checks++; if ({state_dbg, mem_write} !== {3'd0, 1'b0}) begin errors++; $display("FAIL sw_done got %b exp 0000", {state_dbg, mem_write}); end
   endtask

   task automatic test_bz();
      to_exec(6'd7, 5'd0);
      zero_flag = 1'b1;
      #1;
      checks++; if ({state_dbg, pc_write, pc_src} !== {3'd2, 2'b11}) begin errors++; $display("FAIL bz_taken got %b exp 01011", {state_dbg, pc_write, pc_src}); end
      step();
      zero_flag = 1'b0;
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL bz_taken_ret got %0d exp 0", state_dbg); end
      to_exec(6'd7, 5'd0);
      #1;
      checks++; if ({pc_write, pc_src} !== 2'b00) begin errors++; $display("FAIL bz_not_taken got %b exp 00", {pc_write, pc_src}); end
      step();
      checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL bz_nt_ret got %0d exp 0", state_dbg); end
   endtask

   task automatic test_other_branches();
      to_exec(6'd5, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL b_always got %b exp 1", pc_write); end
      step();
      to_exec(6'd6, 5'd0);
      msb_flag = 1'b1;
      #1;
      checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bltz_taken got %b exp 1", pc_write); end
      step();
      msb_flag = 1'b0;
      to_exec(6'd8, 5'd0);
      zero_flag = 1'b1;
      #1;
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bnz_nt got %b exp 0", pc_write); end
      step();
      zero_flag = 1'b0;
   endtask

   task automatic test_carry_branches();
      to_exec(6'd1, 5'd0);
      carry_flag = 1'b0;
      #1;
      checks++; if ({alu_control, alu_src} !== {3'd0, 1'b1}) begin errors++; $display("FAIL addi_alu got %b exp 0001", {alu_control, alu_src}); end
      step();
      step();
      to_exec(6'd2, 5'd0);
      carry_flag = 1'b1;
      #1;
      checks++; if ({alu_control, alu_src} !== {3'd1, 1'b1}) begin errors++; $display("FAIL compi_alu got %b exp 0011", {alu_control, alu_src}); end
      step();
      carry_flag = 1'b0;
      step();
      to_exec(6'd9, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bcy_c0 got %b exp 0", pc_write); end
      step();
      to_exec(6'd1, 5'd0);
      carry_flag = 1'b1;
      step();
      carry_flag = 1'b0;
      step();
      to_exec(6'd10, 5'd0);
      #1;
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL bncy_c1 got %b exp 0", pc_write); end
      step();
      to_exec(6'd9, 5'd0);
      #1;
      checks++; if ({pc_write, pc_src} !== 2'b11) begin errors++; $display("FAIL bcy_c1 got %b exp 11", {pc_write, pc_src}); end
      step();
   endtask

   task automatic test_illegal();
      instr = mk(6'd12, 5'd0);
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      checks++; if ({state_dbg, illegal_instr, halted} !== {3'd1, 2'b00}) begin errors++; $display("FAIL ill_c2 got %b exp 00100", {state_dbg, illegal_instr, halted}); end
      step();
      instr_valid = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({state_dbg, illegal_instr, halted} !== {3'd5, 2'b11}) begin errors++; $display("FAIL ill_halt%0d got %b exp 10111", i, {state_dbg, illegal_instr, halted}); end
         checks++; if ({imem_req, ir_write, reg_write, mem_read, mem_write, pc_write} !== 6'b0) begin errors++; $display("FAIL ill_en%0d got %b exp 000000", i, {imem_req, ir_write, reg_write, mem_read, mem_write, pc_write}); end
         step();
      end
      instr_valid = 1'b0;
      mem_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if ({state_dbg, illegal_instr, halted, imem_req} !== {3'd0, 3'b001}) begin errors++; $display("FAIL ill_rst got %b exp 000001", {state_dbg, illegal_instr, halted, imem_req}); end
      to_exec(6'd0, 5'd8);
      checks++; if ({state_dbg, illegal_instr, halted} !== {3'd5, 2'b11}) begin errors++; $display("FAIL ill_funct got %b exp 10111", {state_dbg, illegal_instr, halted}); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      to_exec(6'd11, 5'd0);
      checks++; if ({state_dbg, illegal_instr, halted} !== {3'd5, 2'b01}) begin errors++; $display("FAIL halt_op got %b exp 10101", {state_dbg, illegal_instr, halted}); end
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      to_exec(6'd1, 5'd0);
      carry_flag = 1'b1;
      step();
      carry_flag = 1'b0;
      step();
      to_exec(6'd4, 5'd0);
      step();
      #1;
      checks++; if ({state_dbg, mem_write} !== {3'd3, 1'b1}) begin errors++; $display("FAIL rmm_mem got %b exp 0111", {state_dbg, mem_write}); end
      rst = 1'b1;
      #1;
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rmm_drop got %b exp 0", mem_write); end
      step();
      rst = 1'b0;
      #1;
      checks++; if ({state_dbg, imem_req, mem_write} !== {3'd0, 2'b10}) begin errors++; $display("FAIL rmm_fetch got %b exp 00010", {state_dbg, imem_req, mem_write}); end
      checks++; if (dut.r_carry_reg !== 1'b0) begin errors++; $display("FAIL rmm_carry got %b exp 0", dut.r_carry_reg); end
   endtask

   initial begin
      test_reset();
      test_rtype_add();
      test_rtype_xor();
      test_lw_wait();
      test_sw_nowait();
      test_bz();
      test_other_branches();
      test_carry_branches();
      test_illegal();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
